// File: rtl/stack_unwinder.sv
// Return-from-subroutine / return-from-interrupt unwinder: pops PC (and CCR flags
// for RTI) from an empty-descending stack, one 16-bit memory word per cycle.
module stack_unwinder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        with_flags,
    input  logic        flush,
    input  logic [31:0] sp_in,
    input  logic [15:0] mem_rdata,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] sp_out,
    output logic        sp_we,
    output logic [31:0] pc_out,
    output logic [2:0]  flags_out,
    output logic        done,
    output logic        stall
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        RD_FL = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_base_sp;
    logic        r_is_rti;
    logic [15:0] r_pc_lo;
    logic [15:0] r_pc_hi;
    logic [31:0] r_pc;
    logic [2:0]  r_flags;

    assign pc_out    = r_pc;
    assign flags_out = r_flags;
    assign stall     = (r_state != IDLE);

    always_comb begin
        w_next   = r_state;
        mem_rd   = 1'b0;
        mem_addr = 32'd0;
        sp_out   = 32'd0;
        sp_we    = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = RD_LO;
            end
            RD_LO: begin
                mem_rd   = 1'b1;
                mem_addr = r_base_sp + 32'd1;
                w_next   = RD_HI;
            end
            RD_HI: begin
                mem_rd   = 1'b1;
                mem_addr = r_base_sp + 32'd2;
                w_next   = r_is_rti ? RD_FL : FIN;
            end
            RD_FL: begin
                mem_rd   = 1'b1;
                mem_addr = r_base_sp + 32'd3;
                w_next   = FIN;
            end
            FIN: begin
                done   = 1'b1;
                sp_we  = 1'b1;
                sp_out = r_base_sp + (r_is_rti ? 32'd3 : 32'd2);
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Abort wins over everything, including a start arriving in IDLE.
        if (flush) begin
            w_next = IDLE;
            done   = 1'b0;
            sp_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_base_sp <= 32'd0;
            r_is_rti  <= 1'b0;
            r_pc_lo   <= 16'd0;
            r_pc_hi   <= 16'd0;
            r_pc      <= 32'd0;
            r_flags   <= 3'd0;
        end else begin
            r_state <= w_next;
            if (!flush) begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_base_sp <= sp_in;
                            r_is_rti  <= with_flags;
                        end
                    end
                    RD_HI: r_pc_lo <= mem_rdata;
                    RD_FL: r_pc_hi <= mem_rdata;
                    // Visible results change only here, so an aborted pop leaves them intact.
                    FIN: begin
                        if (r_is_rti) begin
                            r_pc    <= {r_pc_hi, r_pc_lo};
                            r_flags <= mem_rdata[2:0];
                        end else begin
                            r_pc    <= {mem_rdata, r_pc_lo};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
